// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Assembles command frames (HEADER, CMD, LEN, PAYLOAD[LEN], SUM) from the
//   byte stream of a UART receiver. It checks length, the modulo-256 checksum,
//   receiver line errors and the inter-byte timeout. A good frame is held in a
//   payload buffer until the consumer acknowledges it.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   rx_data/rx_done   received byte and its one-cycle strobe
//   check_err         receiver error flag, sampled with rx_done
//   frame_valid       level, a complete good frame is held
//   frame_cmd/len     CMD and LEN bytes of the held frame
//   frame_ack         consumer releases the held frame
//   rd_addr/rd_data   payload read port, 1-cycle registered latency
//   frame_err         one-cycle pulse on frame rejection
//   err_code          0=checksum 1=length 2=timeout 3=line error
//   drop_cnt          saturating count of bytes dropped while holding
//   busy              parser is not hunting for a header
module uart_frame_parser #(
    parameter logic [7:0] Header    = 8'h55,
    parameter int         MaxLen    = 16,
    parameter int         ClkFre    = 50_000_000,
    parameter int         TimeoutUs = 1000,
    localparam int        AW        = (MaxLen > 1) ? $clog2(MaxLen) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    input  logic          check_err,
    output logic          frame_valid,
    output logic [7:0]    frame_cmd,
    output logic [7:0]    frame_len,
    input  logic          frame_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          frame_err,
    output logic [1:0]    err_code,
    output logic [7:0]    drop_cnt,
    output logic          busy
);

    localparam int         TIMEOUT_CLKS = ClkFre / 1_000_000 * TimeoutUs;
    localparam int         CW           = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0] MAX_LEN_B    = 8'(MaxLen);

    localparam logic [1:0] ERR_SUM  = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_TOUT = 2'd2;
    localparam logic [1:0] ERR_LINE = 2'd3;

    typedef enum logic [2:0] {HUNT, CMD, LEN, DATA, SUM, HOLD} state_t;

    state_t          state, state_n;
    logic [7:0]      sum, sum_n;
    logic [7:0]      idx, idx_n;
    logic [7:0]      cmd_int, cmd_n;
    logic [7:0]      len_int, len_n;
    logic            err_n;
    logic [1:0]      code_n;
    logic            buf_we;
    logic            load_frame;
    logic            drop_inc;
    logic            receiving;
    logic [CW-1:0]   to_cnt;
    logic [7:0]      buf_mem [MaxLen];

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign receiving   = (state == CMD) || (state == LEN) || (state == DATA) || (state == SUM);
    assign frame_valid = (state == HOLD);
    assign busy        = (state != HUNT);

    always_comb begin
        state_n    = state;
        sum_n      = sum;
        idx_n      = idx;
        cmd_n      = cmd_int;
        len_n      = len_int;
        err_n      = 1'b0;
        code_n     = err_code;
        buf_we     = 1'b0;
        load_frame = 1'b0;
        drop_inc   = 1'b0;
        case (state)
            HUNT: begin
                if (rx_done && !check_err && rx_data == Header)
                    state_n = CMD;
            end
            CMD, LEN, DATA, SUM: begin
                if (rx_done) begin
                    if (check_err) begin
                        err_n   = 1'b1;
                        code_n  = ERR_LINE;
                        state_n = HUNT;
                    end else begin
                        case (state)
                            CMD: begin
                                cmd_n   = rx_data;
                                sum_n   = rx_data;
                                state_n = LEN;
                            end
                            LEN: begin
                                if (rx_data > MAX_LEN_B) begin
                                    err_n   = 1'b1;
                                    code_n  = ERR_LEN;
                                    state_n = HUNT;
                                end else begin
                                    len_n   = rx_data;
                                    sum_n   = sum + rx_data;
                                    idx_n   = 8'd0;
                                    state_n = (rx_data == 8'd0) ? SUM : DATA;
                                end
                            end
                            DATA: begin
                                buf_we = 1'b1;
                                sum_n  = sum + rx_data;
                                idx_n  = idx + 8'd1;
                                if (idx == len_int - 8'd1)
                                    state_n = SUM;
                            end
                            SUM: begin
                                if (rx_data == sum) begin
                                    load_frame = 1'b1;
                                    state_n    = HOLD;
                                end else begin
                                    err_n   = 1'b1;
                                    code_n  = ERR_SUM;
                                    state_n = HUNT;
                                end
                            end
                            default: ;
                        endcase
                    end
                end else if (to_cnt == TO_LAST) begin
                    // A byte in the expiry cycle takes the branch above instead.
                    err_n   = 1'b1;
                    code_n  = ERR_TOUT;
                    state_n = HUNT;
                end
            end
            HOLD: begin
                drop_inc = rx_done;
                if (frame_ack)
                    state_n = HUNT;
            end
            default: state_n = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            sum       <= 8'd0;
            idx       <= 8'd0;
            cmd_int   <= 8'd0;
            len_int   <= 8'd0;
            to_cnt    <= '0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
            frame_cmd <= 8'd0;
            frame_len <= 8'd0;
            drop_cnt  <= 8'd0;
            rd_data   <= 8'd0;
        end else begin
            state     <= state_n;
            sum       <= sum_n;
            idx       <= idx_n;
            cmd_int   <= cmd_n;
            len_int   <= len_n;
            frame_err <= err_n;
            err_code  <= code_n;
            if (load_frame) begin
                frame_cmd <= cmd_int;
                frame_len <= len_int;
            end
            if (drop_inc)
                drop_cnt <= sat_inc(drop_cnt);
            // Idle gap counter only runs while a frame is partially received.
            if (rx_done || !receiving)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + CW'(1);
            rd_data <= buf_mem[rd_addr];
        end
    end

    // Payload storage carries no reset; it is only meaningful while holding.
    always_ff @(posedge clk) begin
        if (buf_we)
            buf_mem[idx[AW-1:0]] <= rx_data;
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser
//   Randomized and directed stimulus for uart_frame_parser, compared every
//   cycle against a queue-based reference model of the frame rules.
module tb_uart_frame_parser;

    localparam logic [7:0] HDR   = 8'h55;
    localparam int MAX_LEN       = 16;
    localparam int CLK_FRE       = 2_000_000;
    localparam int TIMEOUT_US    = 50;
    localparam int TCLK          = CLK_FRE / 1_000_000 * TIMEOUT_US;
    localparam int AW            = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_done = 1'b0;
    logic          check_err = 1'b0;
    logic          frame_ack = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          frame_valid;
    logic [7:0]    frame_cmd;
    logic [7:0]    frame_len;
    logic [7:0]    rd_data;
    logic          frame_err;
    logic [1:0]    err_code;
    logic [7:0]    drop_cnt;
    logic          busy;

    uart_frame_parser #(
        .Header(HDR), .MaxLen(MAX_LEN), .ClkFre(CLK_FRE), .TimeoutUs(TIMEOUT_US)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .check_err(check_err), .frame_valid(frame_valid), .frame_cmd(frame_cmd),
        .frame_len(frame_len), .frame_ack(frame_ack), .rd_addr(rd_addr),
        .rd_data(rd_data), .frame_err(frame_err), .err_code(err_code),
        .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: bytes since the header are collected in a queue and a
    // frame is judged when it reaches its declared size.
    logic [7:0] q[$];
    bit         m_hold;
    int         m_idle;
    logic [7:0] m_cmd, m_len, m_drop;
    logic [1:0] m_code;
    bit         m_err;
    logic [7:0] m_pay [256];

    function automatic void model_reset();
        q.delete();
        m_hold = 0; m_idle = 0; m_cmd = 0; m_len = 0;
        m_drop = 0; m_code = 0; m_err = 0;
    endfunction

    function automatic void flag(input logic [1:0] c);
        m_err  = 1;
        m_code = c;
        q.delete();
    endfunction

    function automatic void model_step(input logic [7:0] d, input bit done, input bit ce, input bit ack);
        int s;
        m_err = 0;
        if (m_hold) begin
            if (done && m_drop != 8'd255) m_drop = m_drop + 8'd1;
            if (ack) m_hold = 0;
        end else if (q.size() == 0) begin
            if (done && !ce && d == HDR) begin
                q.push_back(d);
                m_idle = 0;
            end
        end else if (done) begin
            m_idle = 0;
            if (ce) flag(2'd3);
            else begin
                q.push_back(d);
                if (q.size() == 3 && int'(d) > MAX_LEN) flag(2'd1);
                else if (q.size() >= 4 && q.size() == int'(q[2]) + 4) begin
                    s = 0;
                    for (int i = 1; i < q.size() - 1; i++) s += int'(q[i]);
                    if (s % 256 == int'(d)) begin
                        m_hold = 1;
                        m_cmd  = q[1];
                        m_len  = q[2];
                        for (int i = 0; i < int'(q[2]); i++) m_pay[i] = q[3 + i];
                        q.delete();
                    end else flag(2'd0);
                end
            end
        end else begin
            m_idle++;
            if (m_idle == TCLK) flag(2'd2);
        end
    endfunction

    // One clock: drive inputs, advance the model on the edge, check outputs
    // on the falling edge. ra < 0 picks a random read address.
    task automatic tick(input logic [7:0] d, input bit done, input bit ce, input bit ack, input int ra);
        bit         was_hold;
        int         hl;
        logic [7:0] exp_rd;
        logic [AW-1:0] a;
        a = (ra < 0) ? AW'($urandom_range(0, MAX_LEN - 1)) : AW'(ra);
        rx_data = d; rx_done = done; check_err = ce; frame_ack = ack; rd_addr = a;
        was_hold = m_hold;
        hl       = int'(m_len);
        exp_rd   = m_pay[a];
        @(posedge clk);
        model_step(d, done, ce, ack);
        @(negedge clk);
        chk("frame_valid", frame_valid, m_hold);
        chk("frame_err",   frame_err,   m_err);
        chk("err_code",    err_code,    m_code);
        chk("busy",        busy,        (q.size() > 0) || m_hold);
        chk("drop_cnt",    drop_cnt,    m_drop);
        chk("frame_cmd",   frame_cmd,   m_cmd);
        chk("frame_len",   frame_len,   m_len);
        if (was_hold && int'(a) < hl) chk("rd_data", rd_data, exp_rd);
        rx_done = 0; check_err = 0; frame_ack = 0;
    endtask

    task automatic send(input logic [7:0] d, input bit ce = 0, input bit ack = 0);
        tick(d, 1, ce, ack, -1);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(8'($urandom), 0, 0, 0, -1);
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) begin
            send(s[i]);
            idle($urandom_range(0, 2));
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_frame_err",   frame_err,   0);
        chk("rst_err_code",    err_code,    0);
        chk("rst_busy",        busy,        0);
        chk("rst_drop_cnt",    drop_cnt,    0);
        chk("rst_frame_cmd",   frame_cmd,   0);
        chk("rst_frame_len",   frame_len,   0);
        chk("rst_rd_data",     rd_data,     0);
    endtask

    logic [7:0] seq[$];

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1;

        // Good frame, explicit reads, acknowledge.
        seq = '{8'h55, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h64};
        send_seq(seq);
        tick(8'h00, 0, 0, 0, 0);
        tick(8'h00, 0, 0, 0, 1);
        tick(8'h00, 0, 0, 0, 2);
        chk("rd_data_2", rd_data, 8'h30);
        tick(8'h00, 0, 0, 1, -1);
        idle(2);

        // Noise then bad checksum.
        seq = '{8'h00, 8'hAA, 8'h55, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h65};
        send_seq(seq);
        idle(2);

        // Over-length, zero length, line error, short frame.
        seq = '{8'h55, 8'h02, 8'h11};
        send_seq(seq);
        seq = '{8'h55, 8'h07, 8'h00, 8'h07};
        send_seq(seq);
        tick(8'h00, 0, 0, 1, -1);
        seq = '{8'h55, 8'h01};
        send_seq(seq);
        send(8'h02, 1);
        seq = '{8'h55, 8'h01, 8'h01, 8'hAB, 8'hAD};
        send_seq(seq);
        tick(8'h00, 0, 0, 0, 0);
        chk("rd_data_ab", rd_data, 8'hAB);
        tick(8'h00, 0, 0, 1, -1);

        // Timeout: a byte in the last cycle saves the frame, a full gap does not.
        send(8'h55); send(8'h01);
        idle(TCLK - 1);
        send(8'h02);
        idle(TCLK + 2);
        send(8'h55); send(8'h01);
        idle(TCLK + 2);

        // Hold and drop, ack with a byte, saturation.
        seq = '{8'h55, 8'h09, 8'h02, 8'hC1, 8'hC2, 8'h8E};
        send_seq(seq);
        send(8'h11); send(8'h55); send(8'h22);
        chk("drop_3", drop_cnt, 8'd3);
        send(8'h33, 0, 1);
        chk("drop_4", drop_cnt, 8'd4);
        chk("hunt_after_ack", busy, 0);
        seq = '{8'h55, 8'h00, 8'h00, 8'h00};
        send_seq(seq);
        repeat (260) send(8'($urandom));
        chk("drop_sat", drop_cnt, 8'd255);
        tick(8'h00, 0, 0, 1, -1);

        // Reset in mid-frame, then a good frame.
        seq = '{8'h55, 8'h01, 8'h03, 8'h10};
        send_seq(seq);
        #2 rst_n = 0;
        #1 check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1;
        seq = '{8'h55, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h64};
        send_seq(seq);
        tick(8'h00, 0, 0, 1, -1);

        // Randomized frames with corruption, line errors, gaps and acks.
        for (int f = 0; f < 400; f++) begin
            int len, s, gap;
            seq.delete();
            if ($urandom_range(0, 5) == 0) seq.push_back(8'($urandom));
            seq.push_back(HDR);
            seq.push_back(8'($urandom));
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(MAX_LEN + 1, MAX_LEN + 4)
                                             : $urandom_range(0, MAX_LEN);
            seq.push_back(8'(len));
            s = int'(seq[seq.size() - 2]) + len;
            for (int i = 0; i < len; i++) begin
                seq.push_back(8'($urandom));
                s += int'(seq[seq.size() - 1]);
            end
            if ($urandom_range(0, 4) == 0) s += $urandom_range(1, 255);
            seq.push_back(8'(s));
            foreach (seq[i]) begin
                send(seq[i], $urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0);
                case ($urandom_range(0, 49))
                    0:       gap = TCLK + $urandom_range(0, 2);
                    1:       gap = TCLK - 1;
                    default: gap = $urandom_range(0, 2);
                endcase
                for (int g = 0; g < gap; g++)
                    tick(8'($urandom), 0, 0, $urandom_range(0, 4) == 0, -1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
